// File: rtl/rs232_input_if.sv
// ============================================================================
// Module   : rs232_input_if
// Purpose  : Serial line input and received-byte status bundle for rs232_input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rs232_input_if;
    logic       i_rx;
    logic [7:0] o_data;
    logic       o_rx_done;
    logic       o_frame_err;
    logic       o_busy;

    // The receiver core sits on the slave side; whoever drives the line is master.
    modport slave (
        input  i_rx,
        output o_data,
        output o_rx_done,
        output o_frame_err,
        output o_busy
    );

    modport master (
        output i_rx,
        input  o_data,
        input  o_rx_done,
        input  o_frame_err,
        input  o_busy
    );
endinterface

`default_nettype wire

// File: rtl/rs232_input.sv
// ============================================================================
// Module   : rs232_input
// Purpose  : 8N1 UART receiver with mid-bit sampling, glitch rejection and
//            stop-bit framing check.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs232_input #(
    parameter logic [14:0] BPS_CNT_MAX = 15'd217,
    parameter logic [14:0] SAMPLE_PT   = BPS_CNT_MAX >> 1
) (
    input  wire logic       i_clk,
    input  wire logic       i_rst_n,
    rs232_input_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_rx_meta;
    logic        r_rx_s;
    logic        r_rx_d;
    logic [14:0] r_bps_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic [7:0]  r_data;
    logic        r_rx_done;
    logic        r_frame_err;
    logic        r_busy;

    logic        w_sample;
    logic        w_fall;

    assign w_sample = (r_bps_cnt == SAMPLE_PT);
    assign w_fall   = r_rx_d & ~r_rx_s;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_rx_meta   <= 1'b1;
            r_rx_s      <= 1'b1;
            r_rx_d      <= 1'b1;
            r_bps_cnt   <= 15'd0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_data      <= 8'h00;
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_rx_meta   <= bus.i_rx;
            r_rx_s      <= r_rx_meta;
            r_rx_d      <= r_rx_s;
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;

            if (r_state == IDLE) begin
                r_bps_cnt <= 15'd0;
                r_bit_idx <= 3'd0;
                if (w_fall) begin
                    r_state <= START;
                    r_busy  <= 1'b1;
                end
            end else begin
                if (r_bps_cnt == BPS_CNT_MAX - 15'd1)
                    r_bps_cnt <= 15'd0;
                else
                    r_bps_cnt <= r_bps_cnt + 15'd1;

                if (w_sample) begin
                    case (r_state)
                        START: begin
                            if (!r_rx_s) begin
                                r_state   <= DATA;
                                r_bit_idx <= 3'd0;
                            end else begin
                                r_state   <= IDLE;
                                r_bps_cnt <= 15'd0;
                                r_busy    <= 1'b0;
                            end
                        end
                        DATA: begin
                            r_shift[r_bit_idx] <= r_rx_s;
                            r_bit_idx          <= r_bit_idx + 3'd1;
                            if (r_bit_idx == 3'd7)
                                r_state <= STOP;
                        end
                        STOP: begin
                            // Leave at mid-stop-bit so a back-to-back start edge is seen.
                            if (r_rx_s) begin
                                r_data    <= r_shift;
                                r_rx_done <= 1'b1;
                            end else begin
                                r_frame_err <= 1'b1;
                            end
                            r_state   <= IDLE;
                            r_bps_cnt <= 15'd0;
                            r_busy    <= 1'b0;
                        end
                        default: begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.o_data      = r_data;
    assign bus.o_rx_done   = r_rx_done;
    assign bus.o_frame_err = r_frame_err;
    assign bus.o_busy      = r_busy;

endmodule

`default_nettype wire
